lcd_byte_sequencer: RTL and testbench



---
 rtl/lcd_byte_sequencer.sv | 206 ++++++++++++++++++++
 tb/tb_lcd_byte_sequencer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_byte_sequencer.sv
// lcd_byte_sequencer
//   Drives a 16x2 character LCD in 4-bit mode. It runs the power-on init
//   sequence once, then accepts one byte per valid/ready handshake (command
//   or character data). Each byte goes out as two enable-strobed nibbles,
//   and the LCD busy delay is waited out before the next byte is accepted.
//
// Ports
//   Clock      system clock
//   Reset      asynchronous, active-low reset
//   iValid     upstream byte valid
//   iRS        0 = command, 1 = character data
//   iData      byte to write
//   oReady     high only in IDLE; a byte is taken when iValid is also high
//   oInitDone  init sequence finished, sticky until reset
//   oLCD_E     LCD enable strobe
//   oLCD_RS    LCD register select
//   oLCD_RW    LCD read/write, tied low (write only)
//   oLCD_D     LCD DB7..DB4
//
// state     | meaning
// ----------+-----------------------------------------------------------
// PWR_WAIT  | waiting POWERON_DLY after reset
// INIT_NIB  | strobing one of the 0x3,0x3,0x3,0x2 wake-up nibbles
// INIT_WAIT | delay after a wake-up nibble (INIT1/INIT2/CMD by step)
// CFG_BYTE  | load the next configuration byte (0x28,0x06,0x0C,0x01)
// IDLE      | ready for an upstream byte
// NIB_HI    | strobing byte[7:4]
// NIB_LO    | strobing byte[3:0]
// POST_WAIT | LCD busy delay (CLEAR_DLY or CMD_DLY)

module lcd_byte_sequencer #(
  parameter int unsigned POWERON_DLY = 750000,
  parameter int unsigned INIT1_DLY   = 250000,
  parameter int unsigned INIT2_DLY   = 5000,
  parameter int unsigned CMD_DLY     = 2000,
  parameter int unsigned CLEAR_DLY   = 82000,
  parameter int unsigned SETUP       = 3,
  parameter int unsigned E_PULSE     = 13,
  parameter int unsigned HOLD        = 3,
  parameter int unsigned CNT_W       = 20
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       iValid,
  input  logic       iRS,
  input  logic [7:0] iData,
  output logic       oReady,
  output logic       oInitDone,
  output logic       oLCD_E,
  output logic       oLCD_RS,
  output logic       oLCD_RW,
  output logic [3:0] oLCD_D
);

  typedef enum logic [2:0] {
    PWR_WAIT, INIT_NIB, INIT_WAIT, CFG_BYTE, IDLE, NIB_HI, NIB_LO, POST_WAIT
  } state_t;

  localparam int unsigned NIB_LEN = SETUP + E_PULSE + HOLD;

  localparam logic [CNT_W-1:0] LIM_PWR   = CNT_W'(POWERON_DLY - 1);
  localparam logic [CNT_W-1:0] LIM_INIT1 = CNT_W'(INIT1_DLY - 1);
  localparam logic [CNT_W-1:0] LIM_INIT2 = CNT_W'(INIT2_DLY - 1);
  localparam logic [CNT_W-1:0] LIM_CMD   = CNT_W'(CMD_DLY - 1);
  localparam logic [CNT_W-1:0] LIM_CLEAR = CNT_W'(CLEAR_DLY - 1);
  localparam logic [CNT_W-1:0] LIM_NIB   = CNT_W'(NIB_LEN - 1);
  localparam logic [CNT_W-1:0] E_ON      = CNT_W'(SETUP);
  localparam logic [CNT_W-1:0] E_OFF     = CNT_W'(SETUP + E_PULSE);

  state_t           state, next_state;
  logic [CNT_W-1:0] cnt, cnt_limit;
  logic             cnt_done;
  logic [1:0]       init_step;
  logic [1:0]       cfg_idx;
  logic [7:0]       cfg_byte;
  logic [7:0]       byte_q;
  logic             rs_q;
  logic             init_done;
  logic             strobe;
  logic             clear_cmd;

  function automatic logic [7:0] cfg_rom(input logic [1:0] idx);
    case (idx)
      2'd0:    cfg_rom = 8'h28;
      2'd1:    cfg_rom = 8'h06;
      2'd2:    cfg_rom = 8'h0C;
      default: cfg_rom = 8'h01;
    endcase
  endfunction

  assign cfg_byte  = cfg_rom(cfg_idx);
  // clear (0x01) and home (0x02/0x03) need the long busy delay
  assign clear_cmd = !rs_q && (byte_q[7:2] == 6'd0);
  assign cnt_done  = (cnt == cnt_limit);
  assign strobe    = (cnt >= E_ON) && (cnt < E_OFF);

  always_comb begin
    cnt_limit = '0;
    case (state)
      PWR_WAIT:                 cnt_limit = LIM_PWR;
      INIT_NIB, NIB_HI, NIB_LO: cnt_limit = LIM_NIB;
      INIT_WAIT: begin
        case (init_step)
          2'd0:    cnt_limit = LIM_INIT1;
          2'd1:    cnt_limit = LIM_INIT2;
          default: cnt_limit = LIM_CMD;
        endcase
      end
      POST_WAIT:                cnt_limit = clear_cmd ? LIM_CLEAR : LIM_CMD;
      default:                  cnt_limit = '0;
    endcase
  end

  // state register
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) state <= PWR_WAIT;
    else        state <= next_state;
  end

  // next-state logic
  always_comb begin
    next_state = state;
    case (state)
      PWR_WAIT:  if (cnt_done) next_state = INIT_NIB;
      INIT_NIB:  if (cnt_done) next_state = INIT_WAIT;
      INIT_WAIT: if (cnt_done) next_state = (init_step == 2'd3) ? CFG_BYTE : INIT_NIB;
      CFG_BYTE:  next_state = NIB_HI;
      IDLE:      if (iValid) next_state = NIB_HI;
      NIB_HI:    if (cnt_done) next_state = NIB_LO;
      NIB_LO:    if (cnt_done) next_state = POST_WAIT;
      POST_WAIT: begin
        if (cnt_done)
          next_state = (init_done || cfg_idx == 2'd3) ? IDLE : CFG_BYTE;
      end
      default:   next_state = PWR_WAIT;
    endcase
  end

  // phase counter and captured byte
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      cnt       <= '0;
      init_step <= '0;
      cfg_idx   <= '0;
      byte_q    <= '0;
      rs_q      <= 1'b0;
      init_done <= 1'b0;
    end else begin
      cnt <= cnt_done ? '0 : cnt + 1'b1;
      if (state == INIT_WAIT && cnt_done)
        init_step <= init_step + 2'd1;
      if (state == CFG_BYTE) begin
        byte_q <= cfg_byte;
        rs_q   <= 1'b0;
      end
      if (state == IDLE && iValid) begin
        byte_q <= iData;
        rs_q   <= iRS;
      end
      if (state == POST_WAIT && cnt_done && !init_done) begin
        cfg_idx <= cfg_idx + 2'd1;
        if (cfg_idx == 2'd3) init_done <= 1'b1;
      end
    end
  end

  // output logic; D/RS keep the last nibble outside strobe states
  always_comb begin
    oLCD_E  = 1'b0;
    oLCD_RS = rs_q;
    oLCD_D  = byte_q[3:0];
    case (state)
      PWR_WAIT: begin
        oLCD_RS = 1'b0;
        oLCD_D  = 4'h0;
      end
      INIT_NIB: begin
        oLCD_RS = 1'b0;
        oLCD_D  = (init_step == 2'd3) ? 4'h2 : 4'h3;
        oLCD_E  = strobe;
      end
      INIT_WAIT: begin
        oLCD_RS = 1'b0;
        oLCD_D  = (init_step == 2'd3) ? 4'h2 : 4'h3;
      end
      CFG_BYTE: begin
        oLCD_RS = 1'b0;
        oLCD_D  = cfg_byte[7:4];
      end
      NIB_HI: begin
        oLCD_D = byte_q[7:4];
        oLCD_E = strobe;
      end
      NIB_LO: begin
        oLCD_D = byte_q[3:0];
        oLCD_E = strobe;
      end
      default: ;
    endcase
  end

  assign oReady    = (state == IDLE);
  assign oInitDone = init_done;
  assign oLCD_RW   = 1'b0;

endmodule

// File: tb/tb_lcd_byte_sequencer.sv
module tb_lcd_byte_sequencer;

  localparam int POWERON = 20;
  localparam int INIT1   = 10;
  localparam int INIT2   = 5;
  localparam int CMD     = 4;
  localparam int CLEAR   = 12;
  localparam int SETUP   = 1;
  localparam int EPULSE  = 2;
  localparam int HOLD    = 1;
  localparam int NIB     = SETUP + EPULSE + HOLD;

  logic       Clock = 1'b0;
  logic       Reset = 1'b0;
  logic       iValid = 1'b0;
  logic       iRS = 1'b0;
  logic [7:0] iData = 8'h00;
  logic       oReady, oInitDone, oLCD_E, oLCD_RS, oLCD_RW;
  logic [3:0] oLCD_D;

  lcd_byte_sequencer #(
    .POWERON_DLY(POWERON), .INIT1_DLY(INIT1), .INIT2_DLY(INIT2),
    .CMD_DLY(CMD), .CLEAR_DLY(CLEAR), .SETUP(SETUP), .E_PULSE(EPULSE),
    .HOLD(HOLD), .CNT_W(20)
  ) dut (
    .Clock(Clock), .Reset(Reset), .iValid(iValid), .iRS(iRS), .iData(iData),
    .oReady(oReady), .oInitDone(oInitDone), .oLCD_E(oLCD_E),
    .oLCD_RS(oLCD_RS), .oLCD_RW(oLCD_RW), .oLCD_D(oLCD_D)
  );

  always #5 Clock = ~Clock;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int width = 0;
  int last_fall = 0;
  int rw_bad = 0;
  int unstable = 0;
  logic e_prev = 1'b0;
  logic [3:0] d_hold = 4'h0;
  int q_d[$];
  int q_rs[$];
  int q_t[$];
  int q_w[$];
  int init_seq[12] = '{3, 3, 3, 2, 2, 8, 0, 6, 0, 12, 0, 1};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one clock; samples pins 1 time unit after the edge and logs E pulses
  task automatic step();
    @(posedge Clock);
    #1;
    cyc++;
    if (oLCD_RW !== 1'b0) rw_bad++;
    if (oLCD_E && !e_prev) begin
      q_d.push_back(int'(oLCD_D));
      q_rs.push_back(int'(oLCD_RS));
      q_t.push_back(cyc);
      width  = 1;
      d_hold = oLCD_D;
    end else if (oLCD_E) begin
      width++;
      if (oLCD_D !== d_hold) unstable++;
    end else if (e_prev) begin
      q_w.push_back(width);
      last_fall = cyc;
    end
    e_prev = oLCD_E;
  endtask

  task automatic clear_log();
    q_d.delete();
    q_rs.delete();
    q_t.delete();
    q_w.delete();
    e_prev = 1'b0;
  endtask

  // releases reset and checks the full init sequence against the rule list
  task automatic do_init();
    int n;
    int base;
    int mism;
    clear_log();
    mism = 0;
    Reset = 1'b1;
    base = cyc;
    n = 0;
    while (oReady !== 1'b1 && n < 1000) begin
      step();
      n++;
      if (oReady !== oInitDone) mism++;
      if (n == 30 || n == 70) begin
        iValid = 1'b1; iRS = 1'b1; iData = 8'h33;
      end else begin
        iValid = 1'b0;
      end
    end
    chk("init_ready", oReady, 1);
    chk("init_done", oInitDone, 1);
    chk("init_done_vs_ready", mism, 0);
    chk("init_pulse_count", q_d.size(), 12);
    if (q_t.size() > 0) chk("init_first_e", q_t[0] - base, POWERON + SETUP);
    for (int i = 0; i < 12; i++) begin
      if (i < q_d.size()) begin
        chk("init_d", q_d[i], init_seq[i]);
        chk("init_rs", q_rs[i], 0);
      end
      if (i < q_w.size()) chk("init_e_width", q_w[i], EPULSE);
    end
    chk("init_clear_wait", cyc - last_fall, HOLD + CLEAR);
    clear_log();
  endtask

  // one handshake; the model derives nibbles, RS, pulse timing and latency
  task automatic xfer(input logic [7:0] b, input logic rs,
                      input logic nv, input logic [7:0] nd, input logic nrs,
                      input logic scramble, input logic poke, output int acc);
    int n;
    int exp_dly;
    n = 0;
    while (oReady !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    chk("pre_ready", oReady, 1);
    iValid = 1'b1; iRS = rs; iData = b;
    step();
    acc = cyc;
    iValid = nv; iData = nd; iRS = nrs;
    chk("ready_drop", oReady, 0);
    n = 1;
    while (oReady !== 1'b1 && n < 200) begin
      step();
      n++;
      if (scramble && n == 3) iData = 8'hFF;
      if (scramble && n == 7) iData = nd;
      if (poke && n == 2 * NIB + 2) begin
        iValid = 1'b1; iData = 8'h5A; iRS = 1'b1;
      end
      if (poke && n == 2 * NIB + 3) iValid = nv;
    end
    exp_dly = (rs == 1'b0 && b < 8'd4) ? CLEAR : CMD;
    chk("latency", n, 1 + 2 * NIB + exp_dly);
    chk("pulse_count", q_d.size(), 2);
    if (q_d.size() >= 2) begin
      chk("d_hi", q_d[0], int'(b[7:4]));
      chk("d_lo", q_d[1], int'(b[3:0]));
      chk("rs_hi", q_rs[0], int'(rs));
      chk("rs_lo", q_rs[1], int'(rs));
      chk("e_rise_hi", q_t[0] - acc, SETUP);
      chk("e_rise_lo", q_t[1] - acc, NIB + SETUP);
    end
    if (q_w.size() >= 2) begin
      chk("e_width_hi", q_w[0], EPULSE);
      chk("e_width_lo", q_w[1], EPULSE);
    end
    clear_log();
  endtask

  initial begin
    int a1, a2, n, kind, gap;
    logic [7:0] b;
    logic rs;

    // reset values
    #1;
    chk("rst_e", oLCD_E, 0);
    chk("rst_rs", oLCD_RS, 0);
    chk("rst_rw", oLCD_RW, 0);
    chk("rst_d", oLCD_D, 0);
    chk("rst_ready", oReady, 0);
    chk("rst_initdone", oInitDone, 0);
    step();
    step();

    do_init();

    // character 'A'
    xfer(8'h41, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, a1);
    // clear then set-DDRAM
    xfer(8'h01, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, a1);
    xfer(8'h80, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, a1);
    // back-to-back with iValid held and iData disturbed mid-write
    xfer(8'h48, 1'b1, 1'b1, 8'h49, 1'b1, 1'b1, 1'b0, a1);
    xfer(8'h49, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, a2);
    chk("b2b_spacing", a2 - a1, 1 + 2 * NIB + CMD);

    // randomized bytes
    for (int i = 0; i < 30; i++) begin
      kind = $urandom_range(0, 3);
      if (kind == 0) begin
        case ($urandom_range(0, 3))
          0: b = 8'h01;
          1: b = 8'h02;
          2: b = 8'h03;
          default: b = 8'h80;
        endcase
        rs = 1'b0;
      end else begin
        b  = 8'($urandom);
        rs = 1'($urandom);
      end
      xfer(b, rs, 1'b0, 8'($urandom), 1'b0, 1'($urandom), 1'($urandom), a1);
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) step();
    end

    for (int g = 0; g < 40; g++) step();
    chk("no_stray_pulse", q_d.size(), 0);
    chk("rw_low", rw_bad, 0);
    chk("d_stable_in_e", unstable, 0);

    // reset while E is high in NIB_HI
    iValid = 1'b1; iRS = 1'b1; iData = 8'hA5;
    step();
    iValid = 1'b0;
    n = 0;
    while (oLCD_E !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk("mid_e_high", oLCD_E, 1);
    #2 Reset = 1'b0;
    #1;
    chk("arst_e", oLCD_E, 0);
    chk("arst_d", oLCD_D, 0);
    chk("arst_rs", oLCD_RS, 0);
    chk("arst_ready", oReady, 0);
    chk("arst_initdone", oInitDone, 0);
    step();
    step();
    do_init();
    xfer(8'h5A, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, a1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
